// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-lane game engine.
package whack_pkg;

   typedef enum logic [2:0] {IDLE, PICK, LIT, GAP, OVER} state_t;

   // Fibonacci taps 13,4,3,1 expressed as bit positions 12,3,2,0.
   localparam logic [12:0] LFSR_TAPS = 13'h100D;

   function automatic int lane_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/whack_tick_gen.sv
// Difficulty-scaled tick divider: period = BASE_PERIOD >> i_difficulty, one-cycle tick at terminal count.
module whack_tick_gen #(
   parameter int BASE_PERIOD = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_clear,
   input  logic [2:0] i_difficulty,
   output logic       o_tick
);

   localparam int CNT_W = $clog2(BASE_PERIOD + 1);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_term;

   assign w_term = CNT_W'(BASE_PERIOD >> i_difficulty) - CNT_W'(1);
   // >= so a faster difficulty wraps at once when the count is already past the new terminal.
   assign o_tick = !i_clear && (r_cnt >= w_term);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_cnt <= '0;
      else if (i_clear || o_tick)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + CNT_W'(1);
   end

endmodule

// File: rtl/whack_game_core.sv
// Whack-a-lane engine: LFSR lane choice, toggle judging, score, lives and game-over.
// Define WHACK_COMBO_EN to add the streak output and streak-scaled scoring.
module whack_game_core
   import whack_pkg::*;
#(
   parameter int N_LANES     = 8,
   parameter int LFSR_W      = 13,
   parameter int BASE_PERIOD = 50000000,
   parameter int SCORE_W     = 16,
   parameter int LIVES       = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic [2:0]                    difficulty,
   input  logic [N_LANES-1:0]            switch,
   output logic [N_LANES-1:0]            led,
   output logic [lane_w(N_LANES)-1:0]    lane_idx,
   output logic                          hit,
   output logic                          miss,
   output logic [SCORE_W-1:0]            score,
   output logic [3:0]                    lives,
   output logic                          game_over,
   output logic [2:0]                    o_state
`ifdef WHACK_COMBO_EN
   ,
   output logic [3:0]                    streak
`endif
);

   localparam int LANE_W = lane_w(N_LANES);

   state_t              r_state, w_state_nx;
   logic [LFSR_W-1:0]   r_lfsr;
   logic [N_LANES-1:0]  r_sw_q;
   logic [LANE_W-1:0]   r_lane, w_lane_nx;
   logic                r_first, w_first_nx;
   logic                r_hit, w_hit_nx;
   logic                r_miss, w_miss_nx;
   logic [SCORE_W-1:0]  r_score, w_score_nx;
   logic [3:0]          r_lives, w_lives_nx;

   logic [N_LANES-1:0]  w_tog, w_lit_mask;
   logic                w_event, w_tick, w_clear;
   logic [LANE_W-1:0]   w_cand, w_pick;
   logic [SCORE_W-1:0]  w_inc, w_score_inc;
   logic [SCORE_W:0]    w_sum;

   whack_tick_gen #(.BASE_PERIOD(BASE_PERIOD)) u_tick (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (w_clear),
      .i_difficulty (difficulty),
      .o_tick       (w_tick)
   );

   // PICK always precedes LIT, so clearing in PICK restarts the count on every LIT entry.
   assign w_clear    = (r_state == IDLE) || (r_state == PICK);
   assign w_tog      = switch ^ r_sw_q;
   assign w_event    = |w_tog;
   assign w_lit_mask = N_LANES'(1) << r_lane;

   assign w_cand = LANE_W'(32'(r_lfsr) % N_LANES);
   assign w_pick = (!r_first && (w_cand == r_lane)) ?
                   ((w_cand == LANE_W'(N_LANES - 1)) ? '0 : w_cand + LANE_W'(1)) : w_cand;

   assign w_sum       = {1'b0, r_score} + {1'b0, w_inc};
   assign w_score_inc = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];

   always_comb begin
      w_state_nx = r_state;
      w_lane_nx  = r_lane;
      w_first_nx = r_first;
      w_hit_nx   = 1'b0;
      w_miss_nx  = 1'b0;
      w_score_nx = r_score;
      w_lives_nx = r_lives;
      case (r_state)
         IDLE: begin
            if (enable) begin
               w_state_nx = PICK;
               w_score_nx = '0;
               w_lives_nx = 4'(LIVES);
               w_first_nx = 1'b1;
            end
         end
         PICK: begin
            w_lane_nx  = w_pick;
            w_first_nx = 1'b0;
            w_state_nx = LIT;
         end
         LIT: begin
            // A player event in the tick cycle is judged; the tick is ignored.
            if (w_event && (w_tog == w_lit_mask)) begin
               w_hit_nx   = 1'b1;
               w_score_nx = w_score_inc;
               w_state_nx = GAP;
            end else if (w_event || w_tick) begin
               w_miss_nx  = 1'b1;
               w_lives_nx = r_lives - 4'd1;
               w_state_nx = (r_lives == 4'd1) ? OVER : GAP;
            end
         end
         GAP: begin
            if (w_tick)
               w_state_nx = PICK;
         end
         OVER: begin
            if (!enable)
               w_state_nx = IDLE;
         end
         default: w_state_nx = IDLE;
      endcase
      if (!enable && (r_state inside {PICK, LIT, GAP})) begin
         w_state_nx = IDLE;
         w_hit_nx   = 1'b0;
         w_miss_nx  = 1'b0;
         w_score_nx = r_score;
         w_lives_nx = r_lives;
         w_lane_nx  = r_lane;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_lfsr  <= LFSR_W'(1);
         r_sw_q  <= '0;
         r_lane  <= '0;
         r_first <= 1'b1;
         r_hit   <= 1'b0;
         r_miss  <= 1'b0;
         r_score <= '0;
         r_lives <= 4'(LIVES);
      end else begin
         r_state <= w_state_nx;
         r_lfsr  <= {r_lfsr[LFSR_W-2:0], ^(r_lfsr & LFSR_W'(LFSR_TAPS))};
         r_sw_q  <= switch;
         r_lane  <= w_lane_nx;
         r_first <= w_first_nx;
         r_hit   <= w_hit_nx;
         r_miss  <= w_miss_nx;
         r_score <= w_score_nx;
         r_lives <= w_lives_nx;
      end
   end

`ifdef WHACK_COMBO_EN
   logic [3:0] r_streak;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_streak <= '0;
      else if ((r_state == IDLE) && enable)
         r_streak <= '0;
      else if (w_hit_nx)
         r_streak <= (r_streak == 4'hF) ? r_streak : r_streak + 4'd1;
      else if (w_miss_nx)
         r_streak <= '0;
   end

   // Bonus uses the streak before this hit is counted: +1..+4.
   assign w_inc  = SCORE_W'({1'b0, r_streak[3:2]}) + SCORE_W'(1);
   assign streak = r_streak;
`else
   assign w_inc  = SCORE_W'(1);
`endif

   always_comb begin
      led = '0;
      if (r_state == LIT)
         led = w_lit_mask;
      else if (r_state == OVER)
         led = '1;
   end

   assign lane_idx  = r_lane;
   assign hit       = r_hit;
   assign miss      = r_miss;
   assign score     = r_score;
   assign lives     = r_lives;
   assign game_over = (r_state == OVER);
   assign o_state   = r_state;

endmodule

// File: tb/tb_whack_game_core.sv
// Bench for whack_game_core: directed games, queued expected hit/miss records checked by a monitor.
module tb_whack_game_core;
   import whack_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic [2:0] difficulty = 3'd0;
   logic [7:0] switch = 8'h00;
   logic [7:0] led;
   logic [2:0] lane_idx;
   logic       hit, miss, game_over;
   logic [15:0] score;
   logic [3:0] lives;
   logic [2:0] o_state;
`ifdef WHACK_COMBO_EN
   logic [3:0] streak;
`endif

   whack_game_core #(
      .N_LANES(8), .LFSR_W(13), .BASE_PERIOD(64), .SCORE_W(16), .LIVES(3)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .difficulty(difficulty), .switch(switch),
      .led(led), .lane_idx(lane_idx), .hit(hit), .miss(miss), .score(score),
      .lives(lives), .game_over(game_over), .o_state(o_state)
`ifdef WHACK_COMBO_EN
      , .streak(streak)
`endif
   );

   always #5 clk = ~clk;

   // Record layout: {hit, miss, score[15:0], lives[3:0], led[7:0], game_over}
   logic [30:0] exp_q[$];
   int n_checks = 0;
   int n_pass = 0;
   int exp_score = 0;
   int exp_lives = 3;
   int exp_streak = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
   endtask

   task automatic new_game();
      exp_score  = 0;
      exp_lives  = 3;
      exp_streak = 0;
   endtask

   task automatic expect_hit();
      int inc;
      inc = 1;
`ifdef WHACK_COMBO_EN
      inc = 1 + (exp_streak >> 2);
      if (exp_streak < 15) exp_streak++;
`endif
      exp_score += inc;
      exp_q.push_back({1'b1, 1'b0, 16'(exp_score), 4'(exp_lives), 8'h00, 1'b0});
   endtask

   task automatic expect_miss();
      exp_lives--;
      exp_streak = 0;
      if (exp_lives == 0)
         exp_q.push_back({1'b0, 1'b1, 16'(exp_score), 4'd0, 8'hFF, 1'b1});
      else
         exp_q.push_back({1'b0, 1'b1, 16'(exp_score), 4'(exp_lives), 8'h00, 1'b0});
   endtask

   task automatic wait_state(input logic [2:0] st, input int bound, input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (o_state != st && n < bound);
      check(name, 32'(o_state == st), 32'd1);
   endtask

   // Counts negedges until a hit/miss pulse is visible and checks the latency.
   task automatic wait_pulse(input int want_n, input int bound, input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(hit || miss) && n < bound);
      if (!(hit || miss)) n = bound + 1;
      check(name, 32'(n), 32'(want_n));
   endtask

   initial begin : monitor
      logic [30:0] got, want;
      forever begin
         @(negedge clk);
         if (rst && (hit || miss)) begin
            got = {hit, miss, score, lives, led, game_over};
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", {1'b0, got}, 32'h0);
            end else begin
               want = exp_q.pop_front();
               check("pulse_record", {1'b0, got}, {1'b0, want});
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int lane, prev_lane, repeats, found5;
      logic [7:0] seen;

      // Asynchronous reset, checked before the first clock edge.
      #1 rst = 1'b0;
      #2;
      check("rst_led", led, 0);
      check("rst_lane", lane_idx, 0);
      check("rst_pulses", {hit, miss}, 0);
      check("rst_score", score, 0);
      check("rst_lives", lives, 3);
      check("rst_game_over", game_over, 0);
      check("rst_state", o_state, IDLE);
      @(negedge clk) rst = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_stays", o_state, IDLE);
      check("idle_led", led, 0);

      // Game 1: hit lanes until lane 5 has been hit, then wrong and double toggles.
      new_game();
      enable = 1'b1;
      found5 = 0;
      for (int k = 0; k < 60 && found5 == 0; k++) begin
         wait_state(LIT, 200, "reach_lit");
         lane = int'(lane_idx);
         if (k == 0) check("led_onehot", led, 32'(8'(1 << lane)));
         expect_hit();
         switch[lane] = ~switch[lane];
         wait_pulse(1, 4, "hit_latency");
         if (lane == 5) found5 = 1;
         @(negedge clk);
         check("hit_one_cycle", hit, 0);
         check("gap_led", led, 0);
         if (k == 0) switch[0] = ~switch[0];
      end
      check("lane5_hit", found5, 1);

      wait_state(LIT, 200, "reach_lit");
      lane = int'(lane_idx);
      expect_miss();
      switch[lane] = ~switch[lane];
      switch[(lane + 4) % 8] = ~switch[(lane + 4) % 8];
      wait_pulse(1, 4, "double_toggle_latency");

      wait_state(LIT, 200, "reach_lit");
      lane = int'(lane_idx);
      expect_miss();
      switch[(lane + 1) % 8] = ~switch[(lane + 1) % 8];
      wait_pulse(1, 4, "wrong_toggle_latency");

      enable = 1'b0;
      repeat (2) @(negedge clk);
      check("quit_state", o_state, IDLE);
      check("quit_led", led, 0);
      check("quit_score_held", score, 32'(exp_score));

      // Game 2: three timeouts lead to game over.
      new_game();
      enable = 1'b1;
      @(negedge clk);
      check("start_score", score, 0);
      check("start_lives", lives, 3);
      for (int k = 0; k < 3; k++) begin
         wait_state(LIT, 200, "reach_lit");
         expect_miss();
         wait_pulse(64, 200, "timeout_latency");
      end
      repeat (3) @(negedge clk);
      check("over_state", o_state, OVER);
      check("over_flag", game_over, 1);
      check("over_led", led, 8'hFF);
      check("over_lives", lives, 0);
      enable = 1'b0;
      @(negedge clk);
      check("over_exit_state", o_state, IDLE);
      check("over_exit_led", led, 0);
      check("over_exit_flag", game_over, 0);

      // Game 3: difficulty 3 timeout, then 200 fast picks with no repeats.
      new_game();
      difficulty = 3'd3;
      enable = 1'b1;
      wait_state(LIT, 20, "reach_lit");
      prev_lane = int'(lane_idx);
      expect_miss();
      wait_pulse(8, 40, "fast_timeout_latency");
      difficulty = 3'd4;
      repeats = 0;
      seen = 8'h00;
      for (int k = 0; k < 200; k++) begin
         wait_state(LIT, 40, "pick_lit");
         lane = int'(lane_idx);
         if (lane == prev_lane) repeats++;
         seen[lane] = 1'b1;
         prev_lane = lane;
         expect_hit();
         switch[lane] = ~switch[lane];
         wait_pulse(1, 4, "fast_hit_latency");
      end
      check("no_repeat", 32'(repeats), 0);
      check("all_lanes_seen", seen, 8'hFF);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      check("game3_quit", o_state, IDLE);

`ifdef WHACK_COMBO_EN
      // Combo: six hits score 1+1+1+1+2+2 = 8, then a miss clears the streak.
      new_game();
      enable = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_state(LIT, 40, "combo_lit");
         lane = int'(lane_idx);
         expect_hit();
         switch[lane] = ~switch[lane];
         wait_pulse(1, 4, "combo_hit_latency");
      end
      check("combo_score", score, 8);
      check("combo_streak", streak, 6);
      wait_state(LIT, 40, "combo_lit");
      lane = int'(lane_idx);
      expect_miss();
      switch[(lane + 3) % 8] = ~switch[(lane + 3) % 8];
      wait_pulse(1, 4, "combo_miss_latency");
      check("combo_streak_cleared", streak, 0);
      enable = 1'b0;
      repeat (2) @(negedge clk);
`endif

      // Reset asserted mid-LIT acts without a clock edge.
      new_game();
      enable = 1'b1;
      wait_state(LIT, 40, "reset_game_lit");
      lane = int'(lane_idx);
      expect_hit();
      switch[lane] = ~switch[lane];
      wait_pulse(1, 4, "reset_game_hit");
      wait_state(LIT, 40, "reset_game_lit2");
      #2 rst = 1'b0;
      #1;
      check("mid_rst_state", o_state, IDLE);
      check("mid_rst_led", led, 0);
      check("mid_rst_score", score, 0);
      check("mid_rst_lives", lives, 3);
      enable = 1'b0;
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_idle", o_state, IDLE);

      check("queue_drained", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/whack_game_core.md
Name: whack_game_core

Overview:
- Parametrised single-clock game engine for the whack-a-lane game.
- Merges tick generation, pseudo-random lane choice, switch-toggle hit/miss judging, score and lives into one block.
- Adds behaviour the current game lacks: N lanes, no-repeat lane selection, timeout misses, a lives budget, a game-over state and a saturating score.
- Sits between board switches/LEDs and the seven-segment score display.

Parameters:
- N_LANES, 8, number of LEDs/switches (2..16).
- LFSR_W, 13, width of the internal Fibonacci LFSR (13 only in this release; taps 13,4,3,1).
- BASE_PERIOD, 50000000, tick period in clk cycles at difficulty 0; must satisfy BASE_PERIOD>>7 >= 2.
- SCORE_W, 16, score counter width.
- LIVES, 3, misses allowed before game over (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  game run request; level-sensitive.
- difficulty  in  3  speed; tick period = BASE_PERIOD >> difficulty.
- switch  in  N_LANES  raw player switches (synchronised upstream).
- led  out  N_LANES  one-hot lit lane, or all zero.
- lane_idx  out  $clog2(N_LANES)  index of current/last lit lane.
- hit  out  1  one-cycle pulse on a correct hit.
- miss  out  1  one-cycle pulse on a wrong toggle or timeout.
- score  out  SCORE_W  hits this game; saturates at all-ones.
- lives  out  4  remaining lives.
- game_over  out  1  high while in OVER.

Behaviour:
- Reset (rst=0, async): state IDLE; led=0, lane_idx=0, hit=0, miss=0, score=0, lives=LIVES, game_over=0, tick counter=0, LFSR=1 (never all-zero), sw_q=switch on first clk after release.
- LFSR: advances every clk regardless of state.
- Tick: counter counts 0..(BASE_PERIOD>>difficulty)-1 and emits a one-cycle tick at terminal count. Counter is cleared in IDLE and on every entry to LIT. A difficulty change takes effect at the next wrap; if the count already exceeds the new terminal, the counter wraps immediately.
- Toggle detect: tog = switch ^ sw_q, with sw_q <= switch every clk. Any nonzero tog is a player event.
- IDLE:
  - led=0.
  - enable=1 -> PICK; score cleared, lives reloaded to LIVES.
- PICK (1 cycle):
  - cand = LFSR[LFSR_W-1:0] mod N_LANES.
  - If cand == previous lane_idx (and not the first pick of the game), use (cand+1) mod N_LANES.
  - Register lane_idx -> LIT.
- LIT:
  - led = 1<<lane_idx.
  - tog == exactly the lit bit -> hit pulse; score+1 (saturating) -> GAP.
  - tog has any other bit set, including the lit bit plus others -> miss.
  - Tick with no event -> miss.
  - Event and tick in the same cycle: the event wins.
  - On miss: lives-1; if result is 0 -> OVER, else -> GAP.
- GAP:
  - led=0; toggles ignored (no miss).
  - Next tick -> PICK.
- OVER:
  - led = all-ones; game_over=1; score and lives held.
  - enable=0 -> IDLE.
- enable=0 in PICK/LIT/GAP -> IDLE next cycle; no pulse; score held until the next start.
- Latency: hit/miss is asserted in the cycle after the clk edge that first samples the changed switch, and is registered.
- hit and miss are never high together.

Optional Feature:
- Macro: WHACK_COMBO_EN.
- Defined:
  - Adds output streak[3:0], counting consecutive hits (saturates at 15, cleared on miss and game start).
  - Each hit adds 1 + (streak>>2) to score, streak taken before increment, max +4 per hit, saturating.
- Undefined:
  - No streak port.
  - Each hit adds exactly 1.

Decomposition:
- Package whack_pkg holds:
  - state enum {IDLE, PICK, LIT, GAP, OVER};
  - LFSR tap constant;
  - lane-index width localparam helper.
- One sub-module, whack_tick_gen: the difficulty-scaled divider with clear input and tick output.
- LFSR, toggle detect and FSM stay in whack_game_core.

Test Plan:
- Bench settings: N_LANES=8, BASE_PERIOD=64, difficulty=0, LIVES=3.
- Reset mid-LIT: pull rst low -> led=0, score=0, lives=3, state IDLE immediately, without waiting for clk.
- Correct hit: enable=1, wait for LIT with lane 5, toggle switch[5] -> hit pulses for exactly 1 cycle, score=1, led=0 in the next cycle.
- Wrong and double toggle: in LIT on lane 2, toggle switch[2] and switch[6] in the same cycle -> miss, lives=2, score unchanged.
- Timeout to game over: no input across three LIT windows of 64 cycles each -> three miss pulses, lives=0, game_over=1, led=8'hFF; enable=0 -> IDLE, led=0.
- No repeat and speed: 200 consecutive picks give no consecutive equal lane_idx; with difficulty=3, LIT timeout occurs after 8 cycles.
- WHACK_COMBO_EN: 6 consecutive hits -> score = 1+1+1+1+2+2 = 8, streak=6; one miss -> streak=0.
